// File: rtl/seg7_pkg.sv
// Shared constants for the 4-digit 7-segment scanner: segment patterns,
// digit-enable helpers and the BLANK/SHOW scan state type.
package seg7_pkg;

    localparam logic [7:0] SEG_0    = 8'hFC;
    localparam logic [7:0] SEG_1    = 8'h60;
    localparam logic [7:0] SEG_2    = 8'hDA;
    localparam logic [7:0] SEG_3    = 8'hF2;
    localparam logic [7:0] SEG_4    = 8'h66;
    localparam logic [7:0] SEG_5    = 8'hB6;
    localparam logic [7:0] SEG_6    = 8'hBE;
    localparam logic [7:0] SEG_7    = 8'hE0;
    localparam logic [7:0] SEG_8    = 8'hFE;
    localparam logic [7:0] SEG_9    = 8'hF6;
    localparam logic [7:0] SEG_DASH = 8'h02;
    localparam logic [7:0] SEG_OFF  = 8'h00;

    localparam logic [3:0] DIG_OFF  = 4'b1111;

    typedef logic [0:0] state_t;
    localparam state_t ST_BLANK = 1'b0;
    localparam state_t ST_SHOW  = 1'b1;

    // Enables are active-low, so the selected digit is the single zero bit.
    function automatic logic [3:0] digEnable(input logic [1:0] idx);
        digEnable = ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/seg_scan_4dig_if.sv
// Valid/ready handshake carrying a 4-digit BCD word into the display scanner.
interface seg_scan_4dig_if;
    logic        i_valid;
    logic [15:0] i_bcd;
    logic        o_ready;

    modport master (output i_valid, output i_bcd, input  o_ready);
    modport slave  (input  i_valid, input  i_bcd, output o_ready);
endinterface

// File: rtl/seg7_decode.sv
// Combinational BCD-to-7-segment decoder; non-decimal nibbles show a dash.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [7:0] o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        case (i_nib)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_scan_4dig.sv
// Multiplexed 4-digit 7-segment scanner with a one-deep pending buffer.
// Define SEG_SCAN_LZB_EN to enable leading-zero blanking on digits 3..1.
module seg_scan_4dig
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV  = 27_000,
    parameter int BLANK_CYC = 270
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    seg_scan_4dig_if.slave        io_bus,
    output logic [7:0]            o_seg,
    output logic [3:0]            o_dig
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;
    state_t        r_state;
    logic [15:0]   r_pend;
    logic          r_pendValid;
    logic [15:0]   r_disp;

    logic          w_cntLast;
    logic [CW-1:0] w_cntNext;
    logic          w_frameStart;
    logic          w_xfer;
    logic [15:0]   w_dispNow;
    logic [3:0]    w_nib;
    logic [7:0]    w_decSeg;
    logic          w_lzbBlank;

    assign w_cntLast    = (r_cnt == CW'(SCAN_DIV - 1));
    assign w_cntNext    = w_cntLast ? '0 : r_cnt + CW'(1);
    assign w_frameStart = (r_cnt == '0) && (r_idx == 2'd0);
    assign w_xfer       = io_bus.i_valid && io_bus.o_ready;

    // Ready only looks at the pending flag (and reset), never at i_valid.
    assign io_bus.o_ready = !r_pendValid && !i_rst;

    // On the first cycle of a frame the pending word is already what gets shown.
    assign w_dispNow = (w_frameStart && r_pendValid) ? r_pend : r_disp;

    always_comb begin
        w_nib = w_dispNow[3:0];
        case (r_idx)
            2'd0: w_nib = w_dispNow[3:0];
            2'd1: w_nib = w_dispNow[7:4];
            2'd2: w_nib = w_dispNow[11:8];
            2'd3: w_nib = w_dispNow[15:12];
            default: w_nib = w_dispNow[3:0];
        endcase
    end

`ifdef SEG_SCAN_LZB_EN
    always_comb begin
        w_lzbBlank = 1'b0;
        case (r_idx)
            2'd1: w_lzbBlank = (w_dispNow[15:4]  == 12'h000);
            2'd2: w_lzbBlank = (w_dispNow[15:8]  == 8'h00);
            2'd3: w_lzbBlank = (w_dispNow[15:12] == 4'h0);
            default: w_lzbBlank = 1'b0;
        endcase
    end
`else
    assign w_lzbBlank = 1'b0;
`endif

    seg7_decode u_decode (
        .i_nib (w_nib),
        .o_seg (w_decSeg)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_idx   <= 2'd0;
            r_state <= (BLANK_CYC > 0) ? ST_BLANK : ST_SHOW;
        end else begin
            r_cnt   <= w_cntNext;
            r_state <= (int'(w_cntNext) < BLANK_CYC) ? ST_BLANK : ST_SHOW;
            if (w_cntLast) begin
                r_idx <= r_idx + 2'd1;
            end
        end
    end

    // A transfer can only happen while pending is empty, so it never races the frame move.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pend      <= 16'h0000;
            r_pendValid <= 1'b0;
            r_disp      <= 16'h0000;
        end else begin
            if (w_frameStart && r_pendValid) begin
                r_disp <= r_pend;
            end
            if (w_xfer) begin
                r_pend      <= io_bus.i_bcd;
                r_pendValid <= 1'b1;
            end else if (w_frameStart) begin
                r_pendValid <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_seg <= SEG_OFF;
            o_dig <= DIG_OFF;
        end else if (r_state == ST_BLANK) begin
            o_seg <= SEG_OFF;
            o_dig <= DIG_OFF;
        end else begin
            o_seg <= w_lzbBlank ? SEG_OFF : w_decSeg;
            o_dig <= digEnable(r_idx);
        end
    end

endmodule

// File: tb/tb_seg_scan_4dig.sv
// Self-checking bench for seg_scan_4dig (SCAN_DIV=8, BLANK_CYC=2); honours SEG_SCAN_LZB_EN.
// A frame-level reference model is compared against the outputs every cycle.
module tb_seg_scan_4dig;

    localparam int D = 8;
    localparam int B = 2;
    localparam int F = 4 * D;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] seg;
    logic [3:0] dig;

    int checks   = 0;
    int failures = 0;

    seg_scan_4dig_if busIf ();

    seg_scan_4dig #(.SCAN_DIV(D), .BLANK_CYC(B)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (busIf.slave),
        .o_seg  (seg),
        .o_dig  (dig)
    );

    always #5 clk = ~clk;

    logic [7:0] segTable [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
                                  8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};

    function automatic logic [7:0] refSeg(input logic [3:0] n);
        return (n < 4'd10) ? segTable[n] : 8'h02;
    endfunction

    // Reference model: cycle c after reset sits in digit c/D, position c%D of the frame.
    int          mc;
    int          shownC;
    int          mCnt;
    int          mIdx;
    bit          mStarted = 1'b0;
    bit          mPendFull;
    bit          mAccept;
    bit          mLz;
    logic [15:0] mPend;
    logic [15:0] mDisp;
    logic [15:0] mUsed;
    logic [15:0] mShift;
    logic [7:0]  expSeg;
    logic [3:0]  expDig;

    always @(posedge clk) begin
        if (rst) begin
            mc        = 0;
            shownC    = -1;
            mPendFull = 1'b0;
            mPend     = 16'h0000;
            mDisp     = 16'h0000;
            expSeg    = 8'h00;
            expDig    = 4'hF;
            mStarted  = 1'b1;
        end else begin
            mCnt    = mc % D;
            mIdx    = mc / D;
            mUsed   = (mc == 0 && mPendFull) ? mPend : mDisp;
            mAccept = busIf.i_valid && !mPendFull;
            mShift  = mUsed >> (4 * mIdx);
            mLz     = 1'b0;
`ifdef SEG_SCAN_LZB_EN
            mLz     = (mIdx > 0) && (mShift == 16'h0000);
`endif
            if (mCnt < B) begin
                expSeg = 8'h00;
                expDig = 4'hF;
            end else begin
                expDig = 4'hF ^ (4'b0001 << mIdx);
                expSeg = mLz ? 8'h00 : refSeg(mShift[3:0]);
            end
            if (mc == 0 && mPendFull) begin
                mDisp     = mPend;
                mPendFull = 1'b0;
            end
            if (mAccept) begin
                mPend     = busIf.i_bcd;
                mPendFull = 1'b1;
            end
            shownC = mc;
            mc     = (mc + 1) % F;
        end
    end

    always @(negedge clk) begin
        if (mStarted) begin
            checks++;
            if (seg !== expSeg) begin
                failures++;
                $display("[TB] FAIL cycSeg c=%0d got=%h want=%h", shownC, seg, expSeg);
            end
            checks++;
            if (dig !== expDig) begin
                failures++;
                $display("[TB] FAIL cycDig c=%0d got=%b want=%b", shownC, dig, expDig);
            end
            checks++;
            if (busIf.o_ready !== (!mPendFull && !rst)) begin
                failures++;
                $display("[TB] FAIL cycReady c=%0d got=%b want=%b", shownC, busIf.o_ready,
                         (!mPendFull && !rst));
            end
        end
    end

    task automatic checkOutput(input string name, input logic [7:0] wantSeg,
                               input logic [3:0] wantDig);
        checks++;
        if (seg !== wantSeg || dig !== wantDig) begin
            failures++;
            $display("[TB] FAIL %s got seg=%h dig=%b want seg=%h dig=%b",
                     name, seg, dig, wantSeg, wantDig);
        end
    endtask

    task automatic checkReady(input string name, input logic want);
        checks++;
        if (busIf.o_ready !== want) begin
            failures++;
            $display("[TB] FAIL %s got ready=%b want=%b", name, busIf.o_ready, want);
        end
    endtask

    task automatic waitShown(input int target);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (shownC != target && n < 200);
        if (shownC != target) begin
            checks++;
            failures++;
            $display("[TB] FAIL waitShown got c=%0d want c=%0d", shownC, target);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] v, input bit keepValid);
        int n = 0;
        bit rd;
        busIf.i_valid = 1'b1;
        busIf.i_bcd   = v;
        do begin
            rd = busIf.o_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rd && n < 100);
        if (!rd) begin
            checks++;
            failures++;
            $display("[TB] FAIL xferTimeout got ready=0 want ready=1 word=%h", v);
        end
        if (!keepValid) busIf.i_valid = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        busIf.i_valid = 1'b0;
        busIf.i_bcd   = 16'h0000;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkReady("rstReady", 1'b0);
        checkOutput("rstOut", 8'h00, 4'b1111);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("firstOut", 8'h00, 4'b1111);
        checkReady("firstReady", 1'b1);

        // Idle scan of the reset value 0000.
        waitShown(3);  checkOutput("idleDig0", 8'hFC, 4'b1110);
        waitShown(8);  checkOutput("idleBlank1", 8'h00, 4'b1111);
        waitShown(21); checkOutput("idleDig2", 8'hFC, 4'b1011);
        waitShown(31); checkOutput("idleDig3", 8'hFC, 4'b0111);
        repeat (8) @(negedge clk);

        // Mid-frame transfer must wait for the next frame.
        waitShown(10);
        applyStimulus(16'h1234, 1'b0);
        checkReady("readyLowPending", 1'b0);
        waitShown(27); checkOutput("oldFrameDig3", 8'hFC, 4'b0111);
        waitShown(3);  checkOutput("x1234Dig0", 8'h66, 4'b1110);
        checkReady("readyAfterBoundary", 1'b1);
        waitShown(11); checkOutput("x1234Dig1", 8'hF2, 4'b1101);
        waitShown(19); checkOutput("x1234Dig2", 8'hDA, 4'b1011);
        waitShown(27); checkOutput("x1234Dig3", 8'h60, 4'b0111);

        // Back-to-back words: the second stalls until the boundary.
        waitShown(10);
        applyStimulus(16'h5678, 1'b1);
        applyStimulus(16'h9999, 1'b0);
        waitShown(3);  checkOutput("x5678Dig0", 8'hFE, 4'b1110);
        waitShown(27); checkOutput("x5678Dig3", 8'hB6, 4'b0111);
        waitShown(3);  checkOutput("x9999Dig0", 8'hF6, 4'b1110);
        waitShown(27); checkOutput("x9999Dig3", 8'hF6, 4'b0111);

        // Non-decimal nibbles show a dash.
        waitShown(10);
        applyStimulus(16'hF00A, 1'b0);
        waitShown(3);  checkOutput("xF00ADig0", 8'h02, 4'b1110);
        waitShown(11); checkOutput("xF00ADig1", 8'hFC, 4'b1101);
        waitShown(19); checkOutput("xF00ADig2", 8'hFC, 4'b1011);
        waitShown(27); checkOutput("xF00ADig3", 8'h02, 4'b0111);

        // Leading zeros: blanked only with SEG_SCAN_LZB_EN.
        waitShown(10);
        applyStimulus(16'h0042, 1'b0);
        waitShown(3);  checkOutput("x0042Dig0", 8'hDA, 4'b1110);
        waitShown(11); checkOutput("x0042Dig1", 8'h66, 4'b1101);
`ifdef SEG_SCAN_LZB_EN
        waitShown(19); checkOutput("x0042Dig2", 8'h00, 4'b1011);
        waitShown(27); checkOutput("x0042Dig3", 8'h00, 4'b0111);
`else
        waitShown(19); checkOutput("x0042Dig2", 8'hFC, 4'b1011);
        waitShown(27); checkOutput("x0042Dig3", 8'hFC, 4'b0111);
`endif
        waitShown(10);
        applyStimulus(16'h0000, 1'b0);
        waitShown(3);  checkOutput("x0000Dig0", 8'hFC, 4'b1110);
`ifdef SEG_SCAN_LZB_EN
        waitShown(11); checkOutput("x0000Dig1", 8'h00, 4'b1101);
`else
        waitShown(11); checkOutput("x0000Dig1", 8'hFC, 4'b1101);
`endif

        // Random traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            busIf.i_valid = ($urandom_range(0, 3) == 0);
            busIf.i_bcd   = 16'($urandom);
        end
        @(posedge clk);
        #1 busIf.i_valid = 1'b0;

        // Reset during a digit-2 SHOW slot with a word pending.
        waitShown(10);
        applyStimulus(16'h4321, 1'b0);
        waitShown(20);
        @(posedge clk);
        #1 rst = 1'b1;
        #1 checkReady("midRstReady", 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("midRstOut", 8'h00, 4'b1111);
        @(negedge clk);
        checkOutput("afterRstOut", 8'h00, 4'b1111);
        checkReady("afterRstReady", 1'b1);
        waitShown(3);  checkOutput("afterRstDig0", 8'hFC, 4'b1110);
        waitShown(11);
        waitShown(3);  checkOutput("afterRstNextFrame", 8'hFC, 4'b1110);

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_scan_4dig.md
SEG_SCAN_4DIG -- requirements
Module: seg_scan_4dig

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 27_000, giving clock cycles per digit slot (1 kHz per digit at 27 MHz).
REQ-002 SHALL have parameter BLANK_CYC, default 270, giving cycles at the start of each slot with all digits off (anti-ghosting); legal range 0..SCAN_DIV-1.
REQ-003 i_clk  in  1  sole clock, 27 MHz.
REQ-004 i_rst  in  1  synchronous, active-high reset.
REQ-005 i_valid  in  1  producer offers i_bcd this cycle.
REQ-006 i_bcd  in  16  four BCD nibbles: [3:0] is digit 0 (rightmost), [15:12] is digit 3.
REQ-007 o_ready  out  1  block accepts i_bcd this cycle.
REQ-008 o_seg  out  8  segments: bit7=a … bit1=g, bit0=dp, 1=lit.
REQ-009 o_dig  out  4  digit enables, active-low, one-cold; bit n selects digit n.

Function
REQ-010 Transfer SHALL occur on any rising edge with i_valid and o_ready both 1; i_bcd is captured into a pending register.
REQ-011 o_ready SHALL be 1 when pending is empty, 0 when pending is full; it SHALL NOT depend combinationally on i_valid.
REQ-012 Pending SHALL move to the display register on the first cycle of digit-0 slot (frame boundary) and be marked empty that same cycle; a transfer on that exact cycle SHALL be accepted only if pending was empty before it (no overwrite, no loss).
REQ-013 Slot counter SHALL count 0..SCAN_DIV-1 then wrap to 0 and advance the digit index 0→1→2→3→0.
REQ-014 State machine SHALL have states BLANK and SHOW; BLANK for slot counts 0..BLANK_CYC-1, SHOW otherwise; with BLANK_CYC=0, BLANK is never entered.
REQ-015 In BLANK, o_dig SHALL be 4'b1111 and o_seg 8'h00.
REQ-016 In SHOW, o_dig SHALL drive the current index low only, e.g. digit 0 = 4'b1110.
REQ-017 Decode SHALL be 0=FC, 1=60, 2=DA, 3=F2, 4=66, 5=B6, 6=BE, 7=E0, 8=FE, 9=F6 (hex); nibbles A–F SHALL display dash 8'h02.
REQ-018 o_seg and o_dig SHALL be registered: they reflect the slot counter/state with exactly one cycle of latency, glitch-free.
REQ-019 A value SHALL be displayed unchanged for a whole frame; a mid-frame transfer SHALL never affect the frame in progress.

Reset
REQ-020 On i_rst: slot counter 0, digit index 0, state BLANK, pending empty, display register 16'h0000, o_ready 0.
REQ-021 First cycle after reset: o_seg 8'h00, o_dig 4'b1111, o_ready 1.
REQ-022 Reset asserted mid-frame SHALL discard pending and displayed values.

Configuration
REQ-023 Macro SEG_SCAN_LZB_EN SHALL enable leading-zero blanking: digits 3..1 that are 0 with all higher digits also 0 show o_seg 8'h00 with o_dig still driven; digit 0 is always shown.
REQ-024 Without SEG_SCAN_LZB_EN, every digit SHALL be decoded per REQ-017.

Structure
REQ-025 Package seg7_pkg SHALL hold segment constants (SEG_0..SEG_9, SEG_DASH, SEG_OFF), digit-enable constants, and the BLANK/SHOW state type.
REQ-026 Sub-module seg7_decode (4-bit in, 8-bit out, combinational) SHALL implement REQ-017; this block instantiates it once on the muxed nibble.

Verification (SCAN_DIV=8, BLANK_CYC=2)
REQ-027 Reset, then idle 40 cycles -> each digit is dark for 2 cycles, then digit n shows FC for 6 cycles with o_dig one-cold, order 0,1,2,3.
REQ-028 Transfer 16'h1234 mid-frame -> current frame unchanged; next frame digit0=66, digit1=F2, digit2=DA, digit3=60; o_ready low until that frame boundary.
REQ-029 Hold i_valid high with 16'h5678 then 16'h9999 back-to-back -> second transfer stalls until boundary, both frames display in order, none lost.
REQ-030 Transfer 16'hF00A -> digit0 and digit3 show 02, digits 1–2 show FC.
REQ-031 With SEG_SCAN_LZB_EN, transfer 16'h0042 -> digits 3,2 show 00, digit1=66, digit0=DA; 16'h0000 -> only digit0 shows FC.
REQ-032 Assert i_rst during a SHOW slot of digit 2 with pending full -> next cycle outputs per REQ-021, display 0000.
